// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
//   Shared definitions for the guess-who link controller:
//   - screen geometry of the card grid (origin, pitch, card side lengths)
//   - game FSM state encoding
//   - two-bit result encodings used on the result / tx_res / rx_res wires
//   - state_result(): maps an FSM state to the result it reports
// -----------------------------------------------------------------------------
package vga_pkg;

  // Card (r,c) occupies X_ORG+c*X_PITCH .. +A_SIDE and Y_ORG+r*Y_PITCH .. +B_SIDE,
  // both bounds inclusive. Pitch exceeds side so neighbouring cards never overlap.
  localparam int X_ORG   = 100;
  localparam int Y_ORG   = 60;
  localparam int X_PITCH = 120;
  localparam int Y_PITCH = 140;
  localparam int A_SIDE  = 100;
  localparam int B_SIDE  = 120;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_CHECK,
    ST_WIN,
    ST_LOSE,
    ST_DRAW,
    ST_LINK_ERR
  } state_e;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_WIN  = 2'b10;
  localparam logic [1:0] RES_LOSE = 2'b01;
  localparam logic [1:0] RES_DRAW = 2'b11;

  // LINK_ERR reports no result; only link_err flags it.
  function automatic logic [1:0] state_result(input state_e s);
    case (s)
      ST_WIN:  state_result = RES_WIN;
      ST_LOSE: state_result = RES_LOSE;
      ST_DRAW: state_result = RES_DRAW;
      default: state_result = RES_NONE;
    endcase
  endfunction

endpackage

// File: rtl/card_hit_decode.sv
// -----------------------------------------------------------------------------
// card_hit_decode
//   Combinational mouse-to-card decoder for a ROWS x COLS card grid.
//   Ports:
//     xpos, ypos : in  12  mouse position in pixels
//     hit_id     : out ID_W card under the mouse, r*COLS+c+1; 0 = no card
// -----------------------------------------------------------------------------
module card_hit_decode
  import vga_pkg::*;
#(
  parameter int ROWS = 3,
  parameter int COLS = 3,
  parameter int ID_W = 4
) (
  input  logic [11:0]     xpos,
  input  logic [11:0]     ypos,
  output logic [ID_W-1:0] hit_id
);

  localparam int NCARD = ROWS * COLS;

  logic [NCARD-1:0] hit;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int XL = X_ORG + c * X_PITCH;
      localparam int YL = Y_ORG + r * Y_PITCH;
      assign hit[r*COLS+c] = (int'(xpos) >= XL) && (int'(xpos) <= XL + A_SIDE) &&
                             (int'(ypos) >= YL) && (int'(ypos) <= YL + B_SIDE);
    end
  end

  // Cards cannot overlap, but resolve to the lowest index anyway so the
  // output stays well defined if the geometry constants are ever changed.
  always_comb begin
    hit_id = '0;
    for (int i = NCARD - 1; i >= 0; i--) begin
      if (hit[i]) hit_id = ID_W'(i + 1);
    end
  end

endmodule

// File: rtl/guess_link_ctrl.sv
// -----------------------------------------------------------------------------
// guess_link_ctrl
//   Two-board guess-who game controller. The local player clicks on a card to
//   guess the partner's person; the partner's person ID and result arrive over
//   an asynchronous link and are synchronised and de-glitched here.
//   Ports:
//     clk, rst            : clock, synchronous active-high reset
//     play_en             : game is in the guessing phase
//     my_person           : own chosen person, forwarded as tx_id
//     xpos, ypos          : mouse position; mouse_btn : guess button level
//     rx_id/rx_res/rx_present : partner link inputs (asynchronous)
//     tx_id/tx_res/tx_rst : link outputs to partner
//     result              : 00 none, 10 win, 01 lose, 11 draw
//     selected            : last guessed card ID
//     tries_left          : remaining guesses
//     link_err            : partner did not answer within TIMEOUT_CYC cycles
// -----------------------------------------------------------------------------
module guess_link_ctrl
  import vga_pkg::*;
#(
  parameter int ROWS        = 3,
  parameter int COLS        = 3,
  parameter int ID_W        = 4,
  parameter int MAX_TRIES   = 3,
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               play_en,
  input  logic [ID_W-1:0]                    my_person,
  input  logic [11:0]                        xpos,
  input  logic [11:0]                        ypos,
  input  logic                               mouse_btn,
  input  logic [ID_W-1:0]                    rx_id,
  input  logic [1:0]                         rx_res,
  input  logic                               rx_present,
  output logic [ID_W-1:0]                    tx_id,
  output logic [1:0]                         tx_res,
  output logic                               tx_rst,
  output logic [1:0]                         result,
  output logic [ID_W-1:0]                    selected,
  output logic [$clog2(MAX_TRIES+1)-1:0]     tries_left,
  output logic                               link_err
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int STB_W = $clog2(STABLE_CYC + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  // Link synchronisers
  logic [ID_W-1:0] rx_id_s1_q, rx_id_s2_q;
  logic [1:0]      rx_res_s1_q, rx_res_s2_q;
  logic            rx_pres_s1_q, rx_pres_s2_q;

  // Stability filter: id_last_q has held its value for stab_cnt_q cycles
  logic [ID_W-1:0]  id_last_q, id_last_d;
  logic [STB_W-1:0] stab_cnt_q, stab_cnt_d;

  logic                 btn_q;
  state_e               state_q, state_d;
  logic [ID_W-1:0]      selected_q, selected_d;
  logic [TRY_W-1:0]     tries_q, tries_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic [1:0]           result_q, result_d;
  logic                 link_err_q, link_err_d;
  logic [ID_W-1:0]      tx_id_q;

  logic [ID_W-1:0] hit_id;
  logic            click, rx_ready, local_match, partner_won, partner_lost;

  card_hit_decode #(
    .ROWS (ROWS),
    .COLS (COLS),
    .ID_W (ID_W)
  ) u_hit (
    .xpos   (xpos),
    .ypos   (ypos),
    .hit_id (hit_id)
  );

  always_comb begin
    id_last_d = rx_id_s2_q;
    if (rx_id_s2_q != id_last_q)                 stab_cnt_d = STB_W'(1);
    else if (stab_cnt_q != STB_W'(STABLE_CYC))   stab_cnt_d = stab_cnt_q + STB_W'(1);
    else                                         stab_cnt_d = stab_cnt_q;
  end

  // The partner ID is only trusted while the partner is connected and the
  // value has settled; id_last_q is then the accepted ID.
  assign rx_ready     = rx_pres_s2_q && (stab_cnt_q == STB_W'(STABLE_CYC));
  assign local_match  = rx_ready && (id_last_q == selected_q);
  assign partner_won  = (rx_res_s2_q == RES_WIN);
  assign partner_lost = (rx_res_s2_q == RES_LOSE);
  assign click        = mouse_btn && !btn_q;

  always_comb begin
    state_d    = state_q;
    selected_d = selected_q;
    tries_d    = tries_q;
    to_cnt_d   = '0;                 // timeout counter only survives inside CHECK
    link_err_d = link_err_q;
    case (state_q)
      ST_IDLE: begin
        if (play_en) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        if (!play_en)                     state_d = ST_IDLE;
        else if (partner_won)             state_d = ST_LOSE;
        else if (partner_lost)            state_d = ST_WIN;
        else if (click && hit_id != '0) begin
          selected_d = hit_id;
          state_d    = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!play_en)                     state_d = ST_IDLE;
        // partner result beats the local compare; both wins at once is a draw
        else if (partner_won)             state_d = local_match ? ST_DRAW : ST_LOSE;
        else if (partner_lost)            state_d = ST_WIN;
        else if (rx_ready) begin
          if (local_match)                state_d = ST_WIN;
          else if (tries_q > TRY_W'(1)) begin
            tries_d = tries_q - TRY_W'(1);
            state_d = ST_SELECT;
          end else begin
            tries_d = '0;
            state_d = ST_LOSE;
          end
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
          state_d    = ST_LINK_ERR;
          link_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: ;                        // WIN/LOSE/DRAW/LINK_ERR hold until rst
    endcase
    result_d = state_result(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_id_s1_q   <= '0;
      rx_id_s2_q   <= '0;
      rx_res_s1_q  <= '0;
      rx_res_s2_q  <= '0;
      rx_pres_s1_q <= 1'b0;
      rx_pres_s2_q <= 1'b0;
      id_last_q    <= '0;
      stab_cnt_q   <= '0;
      btn_q        <= 1'b0;
      state_q      <= ST_IDLE;
      selected_q   <= '0;
      tries_q      <= TRY_W'(MAX_TRIES);
      to_cnt_q     <= '0;
      result_q     <= RES_NONE;
      link_err_q   <= 1'b0;
      tx_id_q      <= '0;
    end else begin
      rx_id_s1_q   <= rx_id;
      rx_id_s2_q   <= rx_id_s1_q;
      rx_res_s1_q  <= rx_res;
      rx_res_s2_q  <= rx_res_s1_q;
      rx_pres_s1_q <= rx_present;
      rx_pres_s2_q <= rx_pres_s1_q;
      id_last_q    <= id_last_d;
      stab_cnt_q   <= stab_cnt_d;
      btn_q        <= mouse_btn;
      state_q      <= state_d;
      selected_q   <= selected_d;
      tries_q      <= tries_d;
      to_cnt_q     <= to_cnt_d;
      result_q     <= result_d;
      link_err_q   <= link_err_d;
      tx_id_q      <= my_person;
    end
  end

  assign tx_id      = tx_id_q;
  assign tx_res     = result_q;
  assign tx_rst     = rst;
  assign result     = result_q;
  assign selected   = selected_q;
  assign tries_left = tries_q;
  assign link_err   = link_err_q;

endmodule

// File: tb/tb_guess_link_ctrl.sv
module tb_guess_link_ctrl;
  import vga_pkg::*;

  localparam int ROWS = 3, COLS = 3, ID_W = 4, MAX_TRIES = 3;
  localparam int STABLE_CYC = 4, TIMEOUT_CYC = 64;
  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  logic            clk = 1'b0;
  logic            rst, play_en, mouse_btn, rx_present, tx_rst, link_err;
  logic [ID_W-1:0] my_person, rx_id, tx_id, selected;
  logic [11:0]     xpos, ypos;
  logic [1:0]      rx_res, tx_res, result;
  logic [TRY_W-1:0] tries_left;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  guess_link_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .ID_W(ID_W), .MAX_TRIES(MAX_TRIES),
    .STABLE_CYC(STABLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .play_en(play_en), .my_person(my_person),
    .xpos(xpos), .ypos(ypos), .mouse_btn(mouse_btn),
    .rx_id(rx_id), .rx_res(rx_res), .rx_present(rx_present),
    .tx_id(tx_id), .tx_res(tx_res), .tx_rst(tx_rst),
    .result(result), .selected(selected), .tries_left(tries_left), .link_err(link_err)
  );

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    int          exp_sel;
  } vec_t;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; play_en = 1'b0; mouse_btn = 1'b0; rx_present = 1'b1;
    rx_res = 2'b00; rx_id = '0; xpos = '0; ypos = '0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic card_center(input int id, output logic [11:0] x, output logic [11:0] y);
    int r, c;
    r = (id - 1) / COLS;
    c = (id - 1) % COLS;
    x = 12'(X_ORG + c * X_PITCH + A_SIDE / 2);
    y = 12'(Y_ORG + r * Y_PITCH + B_SIDE / 2);
  endtask

  task automatic click_at(input logic [11:0] x, input logic [11:0] y);
    xpos = x; ypos = y; mouse_btn = 1'b1;
    tick();
    mouse_btn = 1'b0;
    tick();
  endtask

  task automatic click_card(input int id);
    logic [11:0] x, y;
    card_center(id, x, y);
    click_at(x, y);
  endtask

  task automatic start_game(input int secret);
    do_reset();
    rx_id = ID_W'(secret); rx_present = 1'b1; play_en = 1'b1;
    tick(STABLE_CYC + 4);
  endtask

  initial begin
    vec_t vt[11];
    logic [11:0] cx, cy;
    int cycles;

    rst = 1'b1; play_en = 1'b0; mouse_btn = 1'b0; rx_present = 1'b0;
    rx_res = '0; rx_id = '0; xpos = '0; ypos = '0; my_person = 4'd9;

    // ---- reset state ----
    tick(2);
    check("rst_result",   result, 0);
    check("rst_selected", selected, 0);
    check("rst_tries",    tries_left, MAX_TRIES);
    check("rst_link_err", link_err, 0);
    check("rst_tx_id",    tx_id, 0);
    check("rst_tx_rst",   tx_rst, 1);
    rst = 1'b0;
    tick();
    check("tx_rst_low",   tx_rst, 0);
    check("tx_id_copy",   tx_id, 9);

    // ---- hit decode boundaries (partner ID 15 never matches a card) ----
    vt[0]  = '{12'd100,  12'd60,  1};   // top-left corner of card 1
    vt[1]  = '{12'd99,   12'd60,  0};
    vt[2]  = '{12'd200,  12'd180, 1};   // bottom-right corner of card 1
    vt[3]  = '{12'd201,  12'd120, 0};
    vt[4]  = '{12'd150,  12'd181, 0};
    vt[5]  = '{12'd150,  12'd59,  0};
    vt[6]  = '{12'd220,  12'd200, 5};   // top-left corner of card (1,1)
    vt[7]  = '{12'd440,  12'd460, 9};   // bottom-right corner of card (2,2)
    vt[8]  = '{12'd441,  12'd400, 0};
    vt[9]  = '{12'd210,  12'd190, 0};   // gap between cards
    vt[10] = '{12'd4000, 12'd4000, 0};
    for (int i = 0; i < 11; i++) begin
      start_game(15);
      click_at(vt[i].x, vt[i].y);
      tick(2);
      check("vec_selected", selected, vt[i].exp_sel);
      check("vec_tries", tries_left, (vt[i].exp_sel != 0) ? MAX_TRIES - 1 : MAX_TRIES);
      check("vec_result", result, 0);
    end

    // ---- correct first guess ----
    start_game(5);
    card_center(5, cx, cy);
    xpos = cx; ypos = cy; mouse_btn = 1'b1;
    tick(); cycles = 1;
    mouse_btn = 1'b0;
    while (result != 2'b10 && cycles < STABLE_CYC + 4) begin
      tick(); cycles++;
    end
    check("win_result", result, 2'b10);
    check("win_tx_res", tx_res, 2'b10);
    check("win_selected", selected, 5);
    check("win_tries", tries_left, 3);

    // ---- three wrong guesses, then a ignored fourth ----
    start_game(2);
    click_card(1); tick(2); check("lose_tries1", tries_left, 2);
    click_card(3); tick(2); check("lose_tries2", tries_left, 1);
    check("lose_mid_result", result, 0);
    click_card(4); tick(2); check("lose_tries3", tries_left, 0);
    check("lose_result", result, 2'b01);
    click_card(5); tick(2);
    check("lose4_sel", selected, 4);
    check("lose4_tries", tries_left, 0);
    check("lose4_result", result, 2'b01);
    check("lose4_tx_res", tx_res, 2'b01);

    // ---- partner won while we are selecting ----
    start_game(9);
    rx_res = 2'b10;
    tick(5);
    check("partner_win_result", result, 2'b01);
    check("partner_win_tries", tries_left, 3);

    // ---- partner win coinciding with local match -> draw ----
    do_reset();
    rx_id = 4'd5; rx_present = 1'b0; play_en = 1'b1;
    tick(STABLE_CYC + 4);
    click_card(5);
    check("draw_wait_result", result, 0);
    rx_res = 2'b10; rx_present = 1'b1;
    tick(6);
    check("draw_result", result, 2'b11);

    // ---- link loss during CHECK ----
    do_reset();
    rx_id = 4'd3; rx_present = 1'b0; play_en = 1'b1;
    tick(8);
    card_center(5, cx, cy);
    xpos = cx; ypos = cy; mouse_btn = 1'b1;
    tick();
    mouse_btn = 1'b0;
    tick(TIMEOUT_CYC - 1);
    check("timeout_early", link_err, 0);
    tick();
    check("timeout_flag", link_err, 1);
    check("timeout_result", result, 0);
    tick(5);
    check("timeout_hold", link_err, 1);

    // ---- toggling rx_id never compares ----
    do_reset();
    play_en = 1'b1;
    card_center(5, cx, cy);
    xpos = cx; ypos = cy;
    for (int i = 0; i < 40; i++) begin
      rx_id = ((i / 2) % 2 != 0) ? 4'd8 : 4'd7;
      mouse_btn = (i == 4);
      tick();
    end
    check("toggle_tries", tries_left, 3);
    check("toggle_result", result, 0);
    check("toggle_sel", selected, 5);

    // ---- reset in CHECK ----
    do_reset();
    my_person = 4'd6; rx_present = 1'b0; play_en = 1'b1;
    tick(6);
    click_card(5);
    tick(3);
    rst = 1'b1;
    tick();
    check("midrst_result", result, 0);
    check("midrst_sel", selected, 0);
    check("midrst_tries", tries_left, MAX_TRIES);
    check("midrst_link_err", link_err, 0);
    check("midrst_tx_id", tx_id, 0);
    check("midrst_tx_rst", tx_rst, 1);
    rst = 1'b0; play_en = 1'b0; rx_present = 1'b1;
    tick(4);
    check("postrst_result", result, 0);
    check("postrst_tx_id", tx_id, 6);

    // ---- held button gives exactly one guess ----
    start_game(15);
    card_center(2, cx, cy);
    xpos = cx; ypos = cy; mouse_btn = 1'b1;
    tick(100);
    mouse_btn = 1'b0;
    tick(3);
    check("hold_tries", tries_left, 2);
    check("hold_sel", selected, 2);

    // ---- random games against a game-rule model ----
    for (int g = 0; g < 20; g++) begin
      int secret, m_tries, m_res, m_sel, guess;
      secret  = int'($urandom_range(1, 9));
      m_tries = MAX_TRIES; m_res = 0; m_sel = 0;
      start_game(secret);
      for (int k = 0; k < 6; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          secret = int'($urandom_range(0, 15));
          rx_id  = ID_W'(secret);
          tick(STABLE_CYC + 4);
        end
        if ($urandom_range(0, 4) == 0) begin
          click_at(12'(210 + $urandom_range(0, 8)), 12'(190 + $urandom_range(0, 8)));
        end else begin
          if (secret >= 1 && secret <= 9 && $urandom_range(0, 2) == 0) guess = secret;
          else guess = int'($urandom_range(1, 9));
          click_card(guess);
          if (m_res == 0) begin
            m_sel = guess;
            if (guess == secret) m_res = 2;
            else begin
              m_tries--;
              if (m_tries == 0) m_res = 1;
            end
          end
        end
        tick(2);
        check("rnd_selected", selected, m_sel);
        check("rnd_tries", tries_left, m_tries);
        check("rnd_result", result, m_res);
        check("rnd_tx_res", tx_res, m_res);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/guess_link_ctrl.md
GUESS_LINK_CTRL -- requirements
Module: guess_link_ctrl

Interface
REQ-001 Parameters SHALL be: ROWS, default 3, card-grid rows; COLS, default 3, card-grid columns; ID_W, default 4, person-ID width; MAX_TRIES, default 3, guesses allowed per game; STABLE_CYC, default 4, cycles the RX ID must hold before use; TIMEOUT_CYC, default 1_000_000, link-wait limit.
REQ-002 Ports SHALL be: clk  in  1  system clock; rst  in  1  synchronous active-high reset.
REQ-003 Ports SHALL be: play_en  in  1  game in guessing phase; my_person  in  ID_W  own chosen person; xpos, ypos  in  12  mouse position; mouse_btn  in  1  guess button level.
REQ-004 Ports SHALL be: rx_id  in  ID_W  partner person ID; rx_res  in  2  partner result; rx_present  in  1  partner board connected, active-high; all three are asynchronous to clk.
REQ-005 Ports SHALL be: tx_id  out  ID_W  own person ID; tx_res  out  2  own result; tx_rst  out  1  reset forwarded to partner.
REQ-006 Ports SHALL be: result  out  2  (00 none, 10 win, 01 lose, 11 draw); selected  out  ID_W  last guessed ID; tries_left  out  $clog2(MAX_TRIES+1)  remaining guesses; link_err  out  1  partner timeout.

Function
REQ-007 rx_id, rx_res and rx_present SHALL each pass through a 2-flop synchroniser before any use.
REQ-008 rx_id SHALL be accepted only after it has held the same synchronised value for STABLE_CYC consecutive cycles.
REQ-009 mouse_btn SHALL be rising-edge detected, and one edge SHALL produce at most one guess.
REQ-010 Card (r,c) SHALL be hit when X_ORG+c*X_PITCH <= xpos <= X_ORG+c*X_PITCH+A_SIDE and the equivalent ypos condition holds with Y_ORG/Y_PITCH/B_SIDE. Card ID SHALL be r*COLS+c+1, so ID 0 means "none".
REQ-011 The FSM SHALL have states IDLE, SELECT, CHECK, WIN, LOSE, DRAW and LINK_ERR.
REQ-012 IDLE SHALL go to SELECT when play_en=1. SELECT and CHECK SHALL return to IDLE when play_en=0, keeping selected and tries_left.
REQ-013 In SELECT, a click edge over a card SHALL register selected and move the FSM to CHECK on the next cycle. A click edge outside every card SHALL be ignored.
REQ-014 In CHECK, once the stable rx_id is available, the FSM SHALL compare it with selected in one cycle:
  - equal -> WIN;
  - unequal with tries_left>1 -> decrement tries_left, return to SELECT;
  - unequal with tries_left=1 -> tries_left=0, LOSE.
REQ-015 In CHECK, a count of TIMEOUT_CYC cycles with rx_present=0 or an unstable rx_id SHALL move the FSM to LINK_ERR and set link_err=1. The counter SHALL clear on leaving CHECK.
REQ-016 In SELECT or CHECK, synchronised rx_res=10 (partner won) SHALL force LOSE, and rx_res=01 SHALL force WIN. Partner result SHALL take priority over a local compare in the same cycle.
REQ-017 If the local compare gives a match in the same cycle that rx_res=10, the FSM SHALL enter DRAW.
REQ-018 WIN, LOSE, DRAW and LINK_ERR SHALL be terminal until rst.
REQ-019 result SHALL be registered: 10 in WIN, 01 in LOSE, 11 in DRAW, 00 otherwise. tx_res SHALL equal result.
REQ-020 tx_id SHALL be a registered copy of my_person, updated every cycle. tx_rst SHALL equal rst.

Reset
REQ-021 On rst=1 at a clk edge, the block SHALL set: state=IDLE, result=00, selected=0, tries_left=MAX_TRIES, link_err=0, tx_id=0, all synchronisers, stability counter and timeout counter to 0.
REQ-022 A reset in any state, including mid-CHECK, SHALL abort the game with no result emitted.

Structure
REQ-023 The state enum, the result encodings and X_ORG, Y_ORG, X_PITCH, Y_PITCH, A_SIDE, B_SIDE SHALL live in vga_pkg.
REQ-024 Hit detection SHALL be a sub-module card_hit_decode (parameters ROWS, COLS, ID_W) that outputs the hit ID combinationally.

Verification
REQ-025 Correct first guess: play_en=1, rx_id=5 stable, click on card (1,1) -> selected=5, result=10 within STABLE_CYC+4 cycles, tries_left=3.
REQ-026 Three wrong guesses with rx_id=2: clicks on IDs 1, 3, 4 -> tries_left goes 2, 1, 0, then result=01; a fourth click leaves all outputs unchanged.
REQ-027 Partner result: rx_res=10 held while in SELECT -> result=01; separately, a local match in the same cycle as rx_res=10 -> result=11.
REQ-028 Link loss: rx_present=0 during CHECK with TIMEOUT_CYC=64 -> link_err=1 after 64 cycles, result=00.
REQ-029 Robustness:
  - rx_id toggling every 2 cycles -> no compare occurs;
  - rst asserted in CHECK -> all REQ-021 values on the next cycle;
  - mouse_btn held for 100 cycles -> exactly one guess.
